// File: rtl/vga_config_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// vga_config_scheduler_pkg
// Shared VGA parameters: config bus width, resolution-select register address,
// resolution codes and the scheduler state encoding.
// -----------------------------------------------------------------------------
package vga_config_scheduler_pkg;

  localparam int         VGA_CONFIG_WIDTH = 8;
  localparam logic [7:0] VGA_ADDR_CONFIG  = 8'h00;

  typedef enum logic [1:0] {
    RES_640X480  = 2'b00,
    RES_800X600  = 2'b01,
    RES_1024X768 = 2'b10,
    RES_INVALID  = 2'b11
  } vga_res_e;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'b00,
    ST_WAIT_FRAME = 2'b01,
    ST_ISSUE      = 2'b10,
    ST_WAIT_LOAD  = 2'b11
  } vga_cfg_state_e;

endpackage

// File: rtl/vga_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// vga_rr_arbiter2
// Two-requester round-robin arbiter, purely combinational.
//   Req  in  2  request vector
//   Ptr  in  1  priority pointer: 0 favours requester 0, 1 favours requester 1
//   Win  out 2  one-hot winner, zero when no request
// -----------------------------------------------------------------------------
module vga_rr_arbiter2 (
  input  logic [1:0] Req,
  input  logic       Ptr,
  output logic [1:0] Win
);

  always_comb begin
    Win = 2'b00;
    case (Req)
      2'b01:   Win = 2'b01;
      2'b10:   Win = 2'b10;
      2'b11:   Win = Ptr ? 2'b10 : 2'b01;
      default: Win = 2'b00;
    endcase
  end

endmodule

// File: rtl/vga_config_scheduler.sv
// -----------------------------------------------------------------------------
// vga_config_scheduler
// Arbitrates resolution-change requests from two requesters and applies the
// winning code to the VGA config block on a frame boundary.
//   Clk          in   rising-edge clock
//   Rst_n        in   synchronous active-low reset
//   Req          in   per-requester change request (level, held until Gnt)
//   Req_res0/1   in   requested resolution code per requester
//   Frame_end    in   end-of-frame pulse
//   Load_config  in   load acknowledge from the VGA config block
//   Gnt          out  one-hot accept pulse
//   C_valid/C_addr/C_data  out  config bus write (one cycle)
//   Cur_res      out  currently applied resolution code
//   Busy         out  high outside IDLE
//   Err          out  pulse on invalid code or load timeout
//
// state       | meaning
// ------------+-------------------------------------------------------------
// IDLE        | arbitrate requests; invalid/unchanged codes finish here
// WAIT_FRAME  | new code latched, waiting for Frame_end
// ISSUE       | config bus write cycle (C_valid high)
// WAIT_LOAD   | waiting for Load_config, bounded by LOAD_TIMEOUT cycles
// -----------------------------------------------------------------------------
module vga_config_scheduler
  import vga_config_scheduler_pkg::*;
#(
  parameter int                      CONFIG_WIDTH    = VGA_CONFIG_WIDTH,
  parameter logic [CONFIG_WIDTH-1:0] ADDR_VGA_CONFIG = CONFIG_WIDTH'(VGA_ADDR_CONFIG),
  parameter int                      LOAD_TIMEOUT    = 15,
  parameter int                      TO_WIDTH        = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic [1:0]              Req,
  input  logic [1:0]              Req_res0,
  input  logic [1:0]              Req_res1,
  input  logic                    Frame_end,
  input  logic                    Load_config,
  output logic [1:0]              Gnt,
  output logic                    C_valid,
  output logic [CONFIG_WIDTH-1:0] C_addr,
  output logic [CONFIG_WIDTH-1:0] C_data,
  output logic [1:0]              Cur_res,
  output logic                    Busy,
  output logic                    Err
);

  vga_cfg_state_e          state_q, state_d;
  logic [1:0]              code_q, code_d;
  logic                    ptr_q, ptr_d;
  logic [TO_WIDTH-1:0]     cnt_q, cnt_d;
  logic [1:0]              gnt_d;
  logic                    err_d;
  logic                    c_valid_d;
  logic [CONFIG_WIDTH-1:0] c_addr_d, c_data_d;
  logic [1:0]              cur_res_d;
  logic                    busy_d;

  logic [1:0] win;
  logic [1:0] win_code;

  vga_rr_arbiter2 u_arb (
    .Req (Req),
    .Ptr (ptr_q),
    .Win (win)
  );

  assign win_code = win[1] ? Req_res1 : Req_res0;

  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = 2'b00;
    err_d     = 1'b0;
    c_valid_d = 1'b0;
    c_addr_d  = '0;
    c_data_d  = '0;
    cur_res_d = Cur_res;

    case (state_q)
      ST_IDLE: begin
        // Req is still held during the Gnt cycle; a second grant there
        // would replay the same request.
        if ((|Req) && (Gnt == 2'b00)) begin
          gnt_d  = win;
          code_d = win_code;
          if (Req == 2'b11) ptr_d = ~ptr_q;
          if (win_code == RES_INVALID)  err_d   = 1'b1;
          else if (win_code != Cur_res) state_d = ST_WAIT_FRAME;
        end
      end

      ST_WAIT_FRAME: begin
        // A Frame_end coinciding with the grant is too early to use.
        if (Frame_end && (Gnt == 2'b00)) begin
          state_d   = ST_ISSUE;
          c_valid_d = 1'b1;
          c_addr_d  = ADDR_VGA_CONFIG;
          c_data_d  = {{(CONFIG_WIDTH-2){1'b0}}, code_q};
        end
      end

      ST_ISSUE: begin
        state_d = ST_WAIT_LOAD;
        cnt_d   = '0;
      end

      ST_WAIT_LOAD: begin
        if (Load_config) begin
          cur_res_d = code_q;
          state_d   = ST_IDLE;
        end else if (cnt_q == TO_WIDTH'(LOAD_TIMEOUT - 1)) begin
          cnt_d   = TO_WIDTH'(LOAD_TIMEOUT);
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= 2'b00;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      Gnt     <= 2'b00;
      Err     <= 1'b0;
      C_valid <= 1'b0;
      C_addr  <= '0;
      C_data  <= '0;
      Cur_res <= RES_640X480;
      Busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      Gnt     <= gnt_d;
      Err     <= err_d;
      C_valid <= c_valid_d;
      C_addr  <= c_addr_d;
      C_data  <= c_data_d;
      Cur_res <= cur_res_d;
      Busy    <= busy_d;
    end
  end

endmodule

// File: tb/tb_vga_config_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_config_scheduler
// Directed bench with a transaction-level reference model compared against
// the DUT outputs on every cycle, plus literal checks at key points.
// -----------------------------------------------------------------------------
module tb_vga_config_scheduler;

  localparam int         TO   = 15;
  localparam logic [7:0] ADDR = 8'h00;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [1:0] Req;
  logic [1:0] Req_res0, Req_res1;
  logic       Frame_end, Load_config;
  logic [1:0] Gnt;
  logic       C_valid;
  logic [7:0] C_addr, C_data;
  logic [1:0] Cur_res;
  logic       Busy, Err;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  vga_config_scheduler dut (
    .Clk         (Clk),
    .Rst_n       (Rst_n),
    .Req         (Req),
    .Req_res0    (Req_res0),
    .Req_res1    (Req_res1),
    .Frame_end   (Frame_end),
    .Load_config (Load_config),
    .Gnt         (Gnt),
    .C_valid     (C_valid),
    .C_addr      (C_addr),
    .C_data      (C_data),
    .Cur_res     (Cur_res),
    .Busy        (Busy),
    .Err         (Err)
  );

  // Reference model: tracks one in-flight transaction by edge timestamps.
  int         e = 0;
  bit         cmp_en = 0;
  bit         m_active;
  bit         m_ptr;
  logic [1:0] m_cur, m_code;
  int         m_last_gnt, m_frame_edge, k;
  bit         win;
  logic [1:0] code;

  logic [1:0] exp_gnt, exp_cur;
  logic       exp_cv, exp_busy, exp_err;
  logic [7:0] exp_addr, exp_data;

  always @(posedge Clk) begin
    e++;
    exp_gnt = 2'b00; exp_err = 1'b0; exp_cv = 1'b0;
    exp_addr = 8'h00; exp_data = 8'h00;
    if (!Rst_n) begin
      m_cur = 2'b00; m_ptr = 0; m_active = 0;
      m_frame_edge = -1; m_last_gnt = -10; m_code = 2'b00;
    end else if (!m_active) begin
      if (Req != 2'b00 && e != m_last_gnt + 1) begin
        if (Req == 2'b11) begin
          win = m_ptr;
          m_ptr = !m_ptr;
        end else begin
          win = Req[1];
        end
        code = win ? Req_res1 : Req_res0;
        exp_gnt = win ? 2'b10 : 2'b01;
        m_last_gnt = e;
        if (code == 2'b11) exp_err = 1'b1;
        else if (code != m_cur) begin
          m_active = 1; m_code = code; m_frame_edge = -1;
        end
      end
    end else if (m_frame_edge < 0) begin
      if (Frame_end && e > m_last_gnt + 1) begin
        m_frame_edge = e;
        exp_cv = 1'b1; exp_addr = ADDR; exp_data = {6'b0, m_code};
      end
    end else begin
      k = e - m_frame_edge;
      if (k >= 2) begin
        if (Load_config) begin
          m_cur = m_code; m_active = 0;
        end else if (k - 1 == TO) begin
          exp_err = 1'b1; m_active = 0;
        end
      end
    end
    exp_busy = m_active;
    exp_cur  = m_cur;
    cmp_en   = 1;
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      checks++;
      if ({Gnt, C_valid, C_addr, C_data, Cur_res, Busy, Err} !==
          {exp_gnt, exp_cv, exp_addr, exp_data, exp_cur, exp_busy, exp_err}) begin
        errors++;
        $display("FAIL outputs edge %0d: got gnt=%b cv=%b addr=%h data=%h cur=%b busy=%b err=%b need gnt=%b cv=%b addr=%h data=%h cur=%b busy=%b err=%b",
                 e, Gnt, C_valid, C_addr, C_data, Cur_res, Busy, Err,
                 exp_gnt, exp_cv, exp_addr, exp_data, exp_cur, exp_busy, exp_err);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h need %0h", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Pulse Frame_end; returns on the negedge of the C_valid cycle.
  task automatic do_frame(input logic [1:0] want_code, input string name);
    Frame_end = 1'b1;
    step(1);
    Frame_end = 1'b0;
    check({name, "_cvalid"}, C_valid, 1);
    check({name, "_caddr"}, C_addr, 0);
    check({name, "_cdata"}, C_data, want_code);
  endtask

  // Nominal acknowledge: Load_config one cycle after C_valid.
  task automatic do_load();
    step(1);
    Load_config = 1'b1;
    step(1);
    Load_config = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; Req = 2'b00; Req_res0 = 2'b00; Req_res1 = 2'b00;
    Frame_end = 1'b0; Load_config = 1'b0;
    step(2);
    Rst_n = 1'b1;
    check("reset_cur", Cur_res, 0);
    check("reset_busy", Busy, 0);
    check("reset_gnt", Gnt, 0);
    check("reset_cvalid", C_valid, 0);

    // Single request, nominal load; stray Load_config in IDLE ignored.
    Load_config = 1'b1;
    step(1);
    Load_config = 1'b0;
    Req = 2'b01; Req_res0 = 2'b01;
    step(1);
    check("s1_gnt", Gnt, 2'b01);
    check("s1_busy", Busy, 1);
    step(1);
    Req = 2'b00;
    step(2);
    do_frame(2'b01, "s1");
    do_load();
    check("s1_cur", Cur_res, 2'b01);
    check("s1_busy_done", Busy, 0);
    check("model_cur_s1", exp_cur, 2'b01);

    // Frame_end in grant cycle ignored; load withheld -> timeout.
    Req = 2'b01; Req_res0 = 2'b10;
    step(1);
    check("to_gnt", Gnt, 2'b01);
    Frame_end = 1'b1;
    step(1);
    Frame_end = 1'b0;
    Req = 2'b00;
    check("to_early_frame", C_valid, 0);
    check("to_busy", Busy, 1);
    step(2);
    do_frame(2'b10, "to");
    Load_config = 1'b1;       // during ISSUE: not a valid acknowledge
    step(1);
    Load_config = 1'b0;
    step(14);
    check("to_busy_15", Busy, 1);
    check("to_err_15", Err, 0);
    step(1);
    check("to_err", Err, 1);
    check("to_busy_end", Busy, 0);
    check("to_cur", Cur_res, 2'b01);

    // Invalid code: Gnt plus Err, no bus transaction, no regrant.
    Req = 2'b01; Req_res0 = 2'b11;
    step(1);
    check("inv_gnt", Gnt, 2'b01);
    check("inv_err", Err, 1);
    check("inv_busy", Busy, 0);
    step(1);
    check("inv_no_regrant", Gnt, 0);
    Req = 2'b00;
    step(2);
    check("inv_cur", Cur_res, 2'b01);

    // Reset during WAIT_FRAME abandons the request.
    Req = 2'b01; Req_res0 = 2'b10;
    step(1);
    check("rst_gnt", Gnt, 2'b01);
    Req = 2'b00;
    step(1);
    Rst_n = 1'b0;
    step(1);
    Rst_n = 1'b1;
    check("rst_busy", Busy, 0);
    check("rst_cur", Cur_res, 0);
    step(1);
    Frame_end = 1'b1;
    step(1);
    Frame_end = 1'b0;
    check("rst_no_cvalid", C_valid, 0);
    step(1);

    // Same code as Cur_res: Gnt only.
    Req = 2'b01; Req_res0 = 2'b00;
    step(1);
    check("same_gnt", Gnt, 2'b01);
    check("same_err", Err, 0);
    check("same_busy", Busy, 0);
    step(1);
    check("same_no_regrant", Gnt, 0);
    Req = 2'b00;
    step(2);

    // Both requesters: pointer favours 0 after reset, then 1.
    Req = 2'b11; Req_res0 = 2'b10; Req_res1 = 2'b01;
    step(1);
    check("both_gnt0", Gnt, 2'b01);
    step(1);
    Req = 2'b10;
    step(2);
    do_frame(2'b10, "both0");
    do_load();
    check("both_cur0", Cur_res, 2'b10);
    step(1);
    check("both_gnt1", Gnt, 2'b10);
    step(1);
    Req = 2'b00;
    step(2);
    do_frame(2'b01, "both1");
    do_load();
    check("both_cur1", Cur_res, 2'b01);
    check("model_cur_both", exp_cur, 2'b01);

    // Both again: pointer toggled to requester 1 by the earlier contention.
    Req = 2'b11; Req_res0 = 2'b00; Req_res1 = 2'b11;
    step(1);
    check("ptr_gnt", Gnt, 2'b10);
    check("ptr_err", Err, 1);
    step(1);
    Req = 2'b00;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
